nasti_mux_n: RTL

N-port to 1-port NASTI multiplexer. Successor to the fixed 8-port write-only mux: the port count is parametrised, the read path is added, and outstanding-transaction tracking is per direction. Sits between several NASTI masters (CPU, DMA, debug) and one shared NASTI slave (memory controller or bus segment). Responses are routed back by ID lookup. Same-ID transactions from different ports are blocked to keep routing unambiguous.

---
 rtl/nasti_mux_n.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nasti_mux_n.sv
// nasti_mux_n: N-port to 1-port NASTI multiplexer with ID-routed responses.
// Writes hold a lock so that W beats follow the granted AW. Reads are unlocked.
// A response whose ID matches no outstanding entry is consumed and flagged.
module nasti_mux_n #(
  parameter int N_PORT     = 4,
  parameter int W_MAX      = 4,
  parameter int R_MAX      = 4,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  // upstream AW
  input  logic [N_PORT-1:0]                      s_aw_valid,
  output logic [N_PORT-1:0]                      s_aw_ready,
  input  logic [N_PORT-1:0][ID_WIDTH-1:0]        s_aw_id,
  input  logic [N_PORT-1:0][ADDR_WIDTH-1:0]      s_aw_addr,
  input  logic [N_PORT-1:0][7:0]                 s_aw_len,
  input  logic [N_PORT-1:0][2:0]                 s_aw_size,
  input  logic [N_PORT-1:0][1:0]                 s_aw_burst,
  input  logic [N_PORT-1:0]                      s_aw_lock,
  input  logic [N_PORT-1:0][3:0]                 s_aw_cache,
  input  logic [N_PORT-1:0][2:0]                 s_aw_prot,
  input  logic [N_PORT-1:0][3:0]                 s_aw_qos,
  input  logic [N_PORT-1:0][3:0]                 s_aw_region,
  input  logic [N_PORT-1:0][USER_WIDTH-1:0]      s_aw_user,
  // upstream W
  input  logic [N_PORT-1:0]                      s_w_valid,
  output logic [N_PORT-1:0]                      s_w_ready,
  input  logic [N_PORT-1:0][DATA_WIDTH-1:0]      s_w_data,
  input  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]    s_w_strb,
  input  logic [N_PORT-1:0]                      s_w_last,
  input  logic [N_PORT-1:0][USER_WIDTH-1:0]      s_w_user,
  // upstream B
  output logic [N_PORT-1:0]                      s_b_valid,
  input  logic [N_PORT-1:0]                      s_b_ready,
  output logic [N_PORT-1:0][ID_WIDTH-1:0]        s_b_id,
  output logic [N_PORT-1:0][1:0]                 s_b_resp,
  output logic [N_PORT-1:0][USER_WIDTH-1:0]      s_b_user,
  // upstream AR
  input  logic [N_PORT-1:0]                      s_ar_valid,
  output logic [N_PORT-1:0]                      s_ar_ready,
  input  logic [N_PORT-1:0][ID_WIDTH-1:0]        s_ar_id,
  input  logic [N_PORT-1:0][ADDR_WIDTH-1:0]      s_ar_addr,
  input  logic [N_PORT-1:0][7:0]                 s_ar_len,
  input  logic [N_PORT-1:0][2:0]                 s_ar_size,
  input  logic [N_PORT-1:0][1:0]                 s_ar_burst,
  input  logic [N_PORT-1:0]                      s_ar_lock,
  input  logic [N_PORT-1:0][3:0]                 s_ar_cache,
  input  logic [N_PORT-1:0][2:0]                 s_ar_prot,
  input  logic [N_PORT-1:0][3:0]                 s_ar_qos,
  input  logic [N_PORT-1:0][3:0]                 s_ar_region,
  input  logic [N_PORT-1:0][USER_WIDTH-1:0]      s_ar_user,
  // upstream R
  output logic [N_PORT-1:0]                      s_r_valid,
  input  logic [N_PORT-1:0]                      s_r_ready,
  output logic [N_PORT-1:0][ID_WIDTH-1:0]        s_r_id,
  output logic [N_PORT-1:0][DATA_WIDTH-1:0]      s_r_data,
  output logic [N_PORT-1:0][1:0]                 s_r_resp,
  output logic [N_PORT-1:0]                      s_r_last,
  output logic [N_PORT-1:0][USER_WIDTH-1:0]      s_r_user,
  // downstream AW
  output logic                                   m_aw_valid,
  input  logic                                   m_aw_ready,
  output logic [ID_WIDTH-1:0]                    m_aw_id,
  output logic [ADDR_WIDTH-1:0]                  m_aw_addr,
  output logic [7:0]                             m_aw_len,
  output logic [2:0]                             m_aw_size,
  output logic [1:0]                             m_aw_burst,
  output logic                                   m_aw_lock,
  output logic [3:0]                             m_aw_cache,
  output logic [2:0]                             m_aw_prot,
  output logic [3:0]                             m_aw_qos,
  output logic [3:0]                             m_aw_region,
  output logic [USER_WIDTH-1:0]                  m_aw_user,
  // downstream W
  output logic                                   m_w_valid,
  input  logic                                   m_w_ready,
  output logic [DATA_WIDTH-1:0]                  m_w_data,
  output logic [DATA_WIDTH/8-1:0]                m_w_strb,
  output logic                                   m_w_last,
  output logic [USER_WIDTH-1:0]                  m_w_user,
  // downstream B
  input  logic                                   m_b_valid,
  output logic                                   m_b_ready,
  input  logic [ID_WIDTH-1:0]                    m_b_id,
  input  logic [1:0]                             m_b_resp,
  input  logic [USER_WIDTH-1:0]                  m_b_user,
  // downstream AR
  output logic                                   m_ar_valid,
  input  logic                                   m_ar_ready,
  output logic [ID_WIDTH-1:0]                    m_ar_id,
  output logic [ADDR_WIDTH-1:0]                  m_ar_addr,
  output logic [7:0]                             m_ar_len,
  output logic [2:0]                             m_ar_size,
  output logic [1:0]                             m_ar_burst,
  output logic                                   m_ar_lock,
  output logic [3:0]                             m_ar_cache,
  output logic [2:0]                             m_ar_prot,
  output logic [3:0]                             m_ar_qos,
  output logic [3:0]                             m_ar_region,
  output logic [USER_WIDTH-1:0]                  m_ar_user,
  // downstream R
  input  logic                                   m_r_valid,
  output logic                                   m_r_ready,
  input  logic [ID_WIDTH-1:0]                    m_r_id,
  input  logic [DATA_WIDTH-1:0]                  m_r_data,
  input  logic [1:0]                             m_r_resp,
  input  logic                                   m_r_last,
  input  logic [USER_WIDTH-1:0]                  m_r_user,
  // unmatched-response pulses
  output logic                                   b_unmatched,
  output logic                                   r_unmatched
);

  localparam int PW = $clog2(N_PORT);
  localparam int WW = $clog2(W_MAX);
  localparam int RW = $clog2(R_MAX);

  // Round-robin pick: returns {found, index}, the first request at or after ptr.
  function automatic logic [PW:0] rr_arb(input logic [N_PORT-1:0] req,
                                         input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int idx;
    res = '0;
    for (int k = N_PORT - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_PORT) idx = idx - N_PORT;
      if (req[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  // Handshakes stay closed until the first clock edge after reset release.
  logic up;

  logic [W_MAX-1:0]    w_vld;
  logic [ID_WIDTH-1:0] w_id   [W_MAX];
  logic [PW-1:0]       w_port [W_MAX];
  logic [R_MAX-1:0]    r_vld;
  logic [ID_WIDTH-1:0] r_id   [R_MAX];
  logic [PW-1:0]       r_port [R_MAX];

  logic [PW-1:0] wr_ptr, rd_ptr, locked_port;
  logic          wr_lock;

  logic [N_PORT-1:0] aw_elig, ar_elig;
  logic              aw_found, ar_found;
  logic [PW-1:0]     aw_grant, ar_grant;
  logic [WW-1:0]     w_slot, b_idx;
  logic [RW-1:0]     r_slot, r_idx;
  logic              b_hit, r_hit;
  logic [PW-1:0]     b_port, r_port_sel;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Eligibility: room in the table, no write lock, and no same-ID entry owned by another port.
  always_comb begin
    aw_elig = '0;
    ar_elig = '0;
    for (int i = 0; i < N_PORT; i++) begin
      aw_elig[i] = s_aw_valid[i] & ~(&w_vld) & ~wr_lock;
      for (int e = 0; e < W_MAX; e++)
        if (w_vld[e] && w_id[e] == s_aw_id[i] && w_port[e] != PW'(i)) aw_elig[i] = 1'b0;
      ar_elig[i] = s_ar_valid[i] & ~(&r_vld);
      for (int e = 0; e < R_MAX; e++)
        if (r_vld[e] && r_id[e] == s_ar_id[i] && r_port[e] != PW'(i)) ar_elig[i] = 1'b0;
    end
  end

  assign {aw_found, aw_grant} = rr_arb(aw_elig, wr_ptr);
  assign {ar_found, ar_grant} = rr_arb(ar_elig, rd_ptr);

  // Lowest free table slot and the ID lookup for incoming responses.
  always_comb begin
    w_slot = '0;
    r_slot = '0;
    b_hit  = 1'b0;
    b_idx  = '0;
    r_hit  = 1'b0;
    r_idx  = '0;
    for (int e = W_MAX - 1; e >= 0; e--) begin
      if (!w_vld[e]) w_slot = WW'(e);
      if (w_vld[e] && w_id[e] == m_b_id) begin
        b_hit = 1'b1;
        b_idx = WW'(e);
      end
    end
    for (int e = R_MAX - 1; e >= 0; e--) begin
      if (!r_vld[e]) r_slot = RW'(e);
      if (r_vld[e] && r_id[e] == m_r_id) begin
        r_hit = 1'b1;
        r_idx = RW'(e);
      end
    end
  end

  assign b_port     = w_port[b_idx];
  assign r_port_sel = r_port[r_idx];

  assign m_aw_valid  = up & aw_found;
  assign m_aw_id     = s_aw_id[aw_grant];
  assign m_aw_addr   = s_aw_addr[aw_grant];
  assign m_aw_len    = s_aw_len[aw_grant];
  assign m_aw_size   = s_aw_size[aw_grant];
  assign m_aw_burst  = s_aw_burst[aw_grant];
  assign m_aw_lock   = s_aw_lock[aw_grant];
  assign m_aw_cache  = s_aw_cache[aw_grant];
  assign m_aw_prot   = s_aw_prot[aw_grant];
  assign m_aw_qos    = s_aw_qos[aw_grant];
  assign m_aw_region = s_aw_region[aw_grant];
  assign m_aw_user   = s_aw_user[aw_grant];

  assign m_w_valid = up & wr_lock & s_w_valid[locked_port];
  assign m_w_data  = s_w_data[locked_port];
  assign m_w_strb  = s_w_strb[locked_port];
  assign m_w_last  = s_w_last[locked_port];
  assign m_w_user  = s_w_user[locked_port];

  assign m_ar_valid  = up & ar_found;
  assign m_ar_id     = s_ar_id[ar_grant];
  assign m_ar_addr   = s_ar_addr[ar_grant];
  assign m_ar_len    = s_ar_len[ar_grant];
  assign m_ar_size   = s_ar_size[ar_grant];
  assign m_ar_burst  = s_ar_burst[ar_grant];
  assign m_ar_lock   = s_ar_lock[ar_grant];
  assign m_ar_cache  = s_ar_cache[ar_grant];
  assign m_ar_prot   = s_ar_prot[ar_grant];
  assign m_ar_qos    = s_ar_qos[ar_grant];
  assign m_ar_region = s_ar_region[ar_grant];
  assign m_ar_user   = s_ar_user[ar_grant];

  assign s_b_id   = {N_PORT{m_b_id}};
  assign s_b_resp = {N_PORT{m_b_resp}};
  assign s_b_user = {N_PORT{m_b_user}};
  assign s_r_id   = {N_PORT{m_r_id}};
  assign s_r_data = {N_PORT{m_r_data}};
  assign s_r_resp = {N_PORT{m_r_resp}};
  assign s_r_last = {N_PORT{m_r_last}};
  assign s_r_user = {N_PORT{m_r_user}};

  // Per-port ready/valid steering; unmatched responses are drained by the mux itself.
  always_comb begin
    s_aw_ready = '0;
    s_ar_ready = '0;
    s_w_ready  = '0;
    s_b_valid  = '0;
    s_r_valid  = '0;
    m_b_ready  = up;
    m_r_ready  = up;
    if (up && aw_found) s_aw_ready[aw_grant] = m_aw_ready;
    if (up && ar_found) s_ar_ready[ar_grant] = m_ar_ready;
    if (up && wr_lock)  s_w_ready[locked_port] = m_w_ready;
    if (up && b_hit) begin
      s_b_valid[b_port] = m_b_valid;
      m_b_ready         = s_b_ready[b_port];
    end
    if (up && r_hit) begin
      s_r_valid[r_port_sel] = m_r_valid;
      m_r_ready             = s_r_ready[r_port_sel];
    end
  end

  assign aw_hs = m_aw_valid & m_aw_ready;
  assign w_hs  = m_w_valid & m_w_ready;
  assign b_hs  = m_b_valid & m_b_ready;
  assign ar_hs = m_ar_valid & m_ar_ready;
  assign r_hs  = m_r_valid & m_r_ready;

  // Write side: table alloc/free, round-robin pointer, W lock and B-unmatched pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up          <= 1'b0;
      w_vld       <= '0;
      wr_ptr      <= '0;
      wr_lock     <= 1'b0;
      locked_port <= '0;
      b_unmatched <= 1'b0;
      for (int e = 0; e < W_MAX; e++) begin
        w_id[e]   <= '0;
        w_port[e] <= '0;
      end
    end else begin
      up          <= 1'b1;
      b_unmatched <= b_hs & ~b_hit;
      if (b_hs && b_hit) w_vld[b_idx] <= 1'b0;
      if (aw_hs) begin
        w_vld[w_slot]  <= 1'b1;
        w_id[w_slot]   <= m_aw_id;
        w_port[w_slot] <= aw_grant;
        wr_ptr         <= (aw_grant == PW'(N_PORT - 1)) ? '0 : aw_grant + 1'b1;
        wr_lock        <= 1'b1;
        locked_port    <= aw_grant;
      end else if (w_hs && m_w_last) begin
        wr_lock <= 1'b0;
      end
    end
  end

  // Read side: table alloc/free on last beat, round-robin pointer and R-unmatched pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      rd_ptr      <= '0;
      r_unmatched <= 1'b0;
      for (int e = 0; e < R_MAX; e++) begin
        r_id[e]   <= '0;
        r_port[e] <= '0;
      end
    end else begin
      r_unmatched <= r_hs & ~r_hit;
      if (r_hs && r_hit && m_r_last) r_vld[r_idx] <= 1'b0;
      if (ar_hs) begin
        r_vld[r_slot]  <= 1'b1;
        r_id[r_slot]   <= m_ar_id;
        r_port[r_slot] <= ar_grant;
        rd_ptr         <= (ar_grant == PW'(N_PORT - 1)) ? '0 : ar_grant + 1'b1;
      end
    end
  end

endmodule
